// File: rtl/gal_sop_sched.sv
// Time-multiplexed sum-of-products evaluator: one shared product-term engine
// scores one product per cycle across NOUT outputs against a captured input vector.
module gal_sop_sched #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4,
  parameter int NOUT  = 2,
  parameter logic [NOUT*((DEPTH > 0) ? DEPTH : 1)*2*WIDTH-1:0] TABLE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  output logic             busy,
  output logic             done,
  output logic [NOUT-1:0]  y,
  output logic [7:0]       neval
);

  localparam int DP = (DEPTH > 0) ? DEPTH : 1;
  localparam int OW = (NOUT > 1) ? $clog2(NOUT) : 1;
  localparam int PW = (DP > 1) ? $clog2(DP) : 1;
  localparam int SW = 2 * WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EVAL,
    ST_DONE
  } state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] a_q_reg;
  logic [OW-1:0]    o_reg;
  logic [PW-1:0]    p_reg;
  logic [7:0]       cnt_reg;
  logic [NOUT-1:0]  work_reg;

  logic [SW-1:0]    slice;
  logic [WIDTH-1:0] field_ok;
  logic             hit;
  logic             advance;
  logic             last_o;
  logic [7:0]       cnt_next;
  logic [NOUT-1:0]  work_next;

  // Table slice for the product currently being scored.
  always_comb begin
    slice = '0;
    if (DEPTH > 0) begin
      slice = TABLE[(int'(o_reg) * DEPTH + int'(p_reg)) * SW +: SW];
    end
  end

  // Field codes: 00 unused, 01 inverted, 10 true, 11 forces the product false.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_field
    always_comb begin
      case (slice[2*gi +: 2])
        2'b00:   field_ok[gi] = 1'b1;
        2'b01:   field_ok[gi] = ~a_q_reg[gi];
        2'b10:   field_ok[gi] = a_q_reg[gi];
        default: field_ok[gi] = 1'b0;
      endcase
    end
  end

  assign hit      = (DEPTH > 0) && (&field_ok);
  assign advance  = (DEPTH == 0) || hit || (p_reg == PW'(DP - 1));
  assign last_o   = (o_reg == OW'(NOUT - 1));
  assign cnt_next = (cnt_reg == 8'hFF) ? 8'hFF : cnt_reg + 8'd1;

  always_comb begin
    work_next        = work_reg;
    work_next[o_reg] = hit;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      a_q_reg   <= '0;
      o_reg     <= '0;
      p_reg     <= '0;
      cnt_reg   <= '0;
      work_reg  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      y         <= '0;
      neval     <= '0;
    end else begin
      done <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            a_q_reg   <= a;
            o_reg     <= '0;
            p_reg     <= '0;
            cnt_reg   <= '0;
            busy      <= 1'b1;
            state_reg <= ST_EVAL;
          end
        end
        ST_EVAL: begin
          cnt_reg  <= cnt_next;
          work_reg <= work_next;
          if (advance) begin
            p_reg <= '0;
            if (last_o) begin
              // Result is published as the DONE state is entered.
              y         <= work_next;
              neval     <= cnt_next;
              done      <= 1'b1;
              state_reg <= ST_DONE;
            end else begin
              o_reg <= o_reg + OW'(1);
            end
          end else begin
            p_reg <= p_reg + PW'(1);
          end
        end
        ST_DONE: begin
          busy      <= 1'b0;
          state_reg <= ST_IDLE;
        end
        default: begin
          busy      <= 1'b0;
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gal_sop_sched.sv
// Directed bench for gal_sop_sched with WIDTH=2, DEPTH=2, NOUT=2, TABLE=16'h325A
// (Y0 = A0&A1 | ~A0&~A1, Y1 = A0).
module tb_gal_sop_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [1:0] a;
  logic       busy;
  logic       done;
  logic [1:0] y;
  logic [7:0] neval;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [1:0] a;
    logic [1:0] exp_y;
    int         exp_neval;
  } vec_t;

  vec_t vecs [4];

  gal_sop_sched #(
    .WIDTH(2),
    .DEPTH(2),
    .NOUT (2),
    .TABLE(16'h325A)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a),
    .busy (busy),
    .done (done),
    .y    (y),
    .neval(neval)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One evaluation; mode 0 plain, 1 toggles A while busy, 2 holds START high while busy.
  task automatic run(input string tag, input logic [1:0] av, input logic [1:0] exp_y,
                     input int exp_neval, input int mode);
    int edges;
    @(negedge clk);
    start = 1'b1;
    a     = av;
    @(posedge clk);
    #1;
    if (mode != 2) start = 1'b0;
    edges = 1;
    while (!done && edges < 20) begin
      if (mode == 1) a = ~a;
      @(posedge clk);
      #1;
      edges++;
    end
    chk({tag, " done_seen"}, int'(done), 1);
    chk({tag, " latency"}, edges, exp_neval + 1);
    chk({tag, " y"}, int'(y), int'(exp_y));
    chk({tag, " neval"}, int'(neval), exp_neval);
    chk({tag, " busy_in_done"}, int'(busy), 1);
    @(posedge clk);
    #1;
    start = 1'b0;
    chk({tag, " done_pulse_1cyc"}, int'(done), 0);
    chk({tag, " idle_after"}, int'(busy), 0);
    $display("[TB] run %s a=%b y=%b neval=%0d edges=%0d", tag, av, y, neval, edges);
  endtask

  initial begin
    vecs[0] = '{a: 2'b11, exp_y: 2'b11, exp_neval: 2};
    vecs[1] = '{a: 2'b00, exp_y: 2'b01, exp_neval: 4};
    vecs[2] = '{a: 2'b01, exp_y: 2'b10, exp_neval: 3};
    vecs[3] = '{a: 2'b10, exp_y: 2'b00, exp_neval: 4};

    rst   = 1'b1;
    start = 1'b0;
    a     = 2'b00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset y", int'(y), 0);
    chk("reset done", int'(done), 0);
    chk("reset busy", int'(busy), 0);
    chk("reset neval", int'(neval), 0);
    $display("[TB] reset y=%b done=%b busy=%b neval=%0d", y, done, busy, neval);
    rst = 1'b0;

    for (int i = 0; i < 4; i++) begin
      run($sformatf("vec%0d", i), vecs[i].a, vecs[i].exp_y, vecs[i].exp_neval, 0);
    end

    // Result holds while idle.
    repeat (5) @(posedge clk);
    #1;
    chk("hold y", int'(y), 0);
    chk("hold neval", int'(neval), 4);
    $display("[TB] hold y=%b neval=%0d", y, neval);

    run("toggle_a", 2'b01, 2'b10, 3, 1);
    run("start_spam", 2'b11, 2'b11, 2, 2);
    run("after_spam", 2'b00, 2'b01, 4, 0);

    // Reset in the middle of an evaluation: no DONE, state cleared.
    @(negedge clk);
    start = 1'b1;
    a     = 2'b00;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst y", int'(y), 0);
    chk("midrst busy", int'(busy), 0);
    chk("midrst done", int'(done), 0);
    chk("midrst neval", int'(neval), 0);
    rst = 1'b0;
    begin
      int seen;
      seen = 0;
      repeat (6) begin
        @(posedge clk);
        #1;
        if (done) seen++;
      end
      chk("midrst no_done", seen, 0);
    end
    $display("[TB] midrst y=%b busy=%b neval=%0d", y, busy, neval);

    run("post_rst", 2'b01, 2'b10, 3, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
